// File: rtl/volume_envelope_array.sv
// Multi-channel volume envelope generator for the audio mixer.
// Each channel restarts on trigger and steps its volume every N ticks.
module volume_envelope_array #(
  parameter int NUM_CH = 4,
  parameter int VOL_W = 4,
  parameter int PER_W = 3,
  localparam int CFG_W = VOL_W + 1 + PER_W,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock_64,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [CFG_W-1:0]        wr_data,
  input  logic [NUM_CH-1:0]       trigger,
  output logic [NUM_CH*VOL_W-1:0] volume,
  output logic [NUM_CH-1:0]       dac_en,
  output logic [NUM_CH-1:0]       env_active
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } state_t;

  localparam logic [VOL_W-1:0] VMAX = {VOL_W{1'b1}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d, eff;
    logic [VOL_W-1:0] vol_q, vol_d, e_vol, run_lim, e_lim;
    logic [PER_W-1:0] cnt_q, cnt_d, per_q, per_d, e_per;
    logic             dir_q, dir_d, e_inc, e_on, wr_hit;
    logic [VOL_W:0]   step;

    assign wr_hit = wr_en && (int'(wr_ch) == c);
    assign eff = wr_hit ? wr_data : cfg_q;
    assign e_vol = eff[CFG_W-1 -: VOL_W];
    assign e_inc = eff[PER_W];
    assign e_per = eff[PER_W-1:0];
    assign e_on = |eff[CFG_W-1:PER_W];
    assign e_lim = e_inc ? VMAX : '0;
    assign run_lim = dir_q ? VMAX : '0;

    // Extra headroom bit; the limit check stops before any wrap
    assign step = dir_q ? ({1'b0, vol_q} + (VOL_W+1)'(1))
                        : ({1'b0, vol_q} - (VOL_W+1)'(1));

    always_comb begin
      state_d = state_q;
      cfg_d = eff;
      vol_d = vol_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      per_d = per_q;
      if (wr_hit && !e_on) begin
        state_d = IDLE;
        vol_d = '0;
      end else if (trigger[c] && e_on) begin
        vol_d = e_vol;
        dir_d = e_inc;
        per_d = e_per;
        cnt_d = e_per;
        if (e_per == '0)
          state_d = HOLD;
        else if (e_vol == e_lim)
          state_d = DONE;
        else
          state_d = RUN;
      end else if (state_q == RUN) begin
        if (cnt_q == PER_W'(1)) begin
          cnt_d = per_q;
          vol_d = step[VOL_W-1:0];
          if (step == {1'b0, run_lim})
            state_d = DONE;
        end else begin
          cnt_d = cnt_q - PER_W'(1);
        end
      end
    end

    always_ff @(posedge clock_64 or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cfg_q <= '0;
        vol_q <= '0;
        cnt_q <= '0;
        dir_q <= 1'b0;
        per_q <= '0;
      end else begin
        state_q <= state_d;
        cfg_q <= cfg_d;
        vol_q <= vol_d;
        cnt_q <= cnt_d;
        dir_q <= dir_d;
        per_q <= per_d;
      end
    end

    assign volume[c*VOL_W +: VOL_W] = vol_q;
    assign dac_en[c] = |cfg_q[CFG_W-1:PER_W];
    assign env_active[c] = (state_q == RUN);
  end

endmodule

// File: doc/volume_envelope_array.md
# volume_envelope_array

Parametrised multi-channel volume envelope generator for the audio mixer. Holds a shadow envelope register per channel, restarts the envelope on a per-channel trigger, and steps each channel's volume once every programmed number of 64 Hz ticks. Steps saturate at 0 or at the maximum volume. Registered volumes and status flags feed the channel DACs and the mixer.

## Interface
- NUM_CH, 4, number of independent envelope channels (1..8)
- VOL_W, 4, volume width; maximum volume VMAX = 2^VOL_W − 1
- PER_W, 3, step-period field width; period 0 means no stepping
- CFG_W, derived = VOL_W+1+PER_W; config word layout is {init_vol[VOL_W], increase[1], period[PER_W]}
- CH_W, derived = max(1, $clog2(NUM_CH))

Ports:
- clock_64  in  1  envelope tick clock; each rising edge is one tick
- reset  in  1  asynchronous, active-high
- wr_en  in  1  config write strobe, one cycle
- wr_ch  in  CH_W  target channel of the write; values ≥ NUM_CH are ignored
- wr_data  in  CFG_W  config word
- trigger  in  NUM_CH  per-channel envelope restart strobe
- volume  out  NUM_CH*VOL_W  current volume; channel c is at [c*VOL_W +: VOL_W]
- dac_en  out  NUM_CH  channel DAC enabled: shadow {init_vol, increase} ≠ 0
- env_active  out  NUM_CH  channel is in RUN

## Operation
- Per-channel state: cfg (CFG_W), vol (VOL_W), cnt (PER_W), latched dir and period, and FSM state IDLE / HOLD / RUN / DONE.
- Write: when wr_en is high, cfg[wr_ch] <= wr_data. A write does not restart or alter a running envelope.
  - If the written {init_vol, increase} is 0, the DAC turns off. The channel goes to IDLE, vol <= 0.
- Trigger on channel c, using the effective cfg. The effective cfg is wr_data when a write to c occurs in the same cycle; otherwise it is cfg[c].
  - DAC off: the trigger is ignored and the channel stays IDLE.
  - Otherwise: vol <= init_vol, dir and period are latched, cnt <= period.
  - Next state:
    - HOLD if period = 0.
    - DONE if init_vol is already at the limit (VMAX when increasing, 0 when decreasing).
    - RUN otherwise.
- RUN, each tick:
  - If cnt = 1: cnt <= period, and vol steps ±1. If the new vol equals the limit, go to DONE.
  - Otherwise: cnt <= cnt − 1.
- HOLD and DONE: vol is static. Only a trigger, a DAC-off write, or reset leaves these states.
- Latched dir and period are not affected by later writes until the next trigger.
- Arithmetic: the step is computed in VOL_W+1 bits. The limit check guarantees no wrap. vol never leaves 0..VMAX.
- Channels are fully independent. Triggers on several channels in the same tick are all honoured.

## Timing
- Reset: all cfg = 0, vol = 0, cnt = 0, state IDLE. volume = 0, dac_en = 0, env_active = 0. These hold while reset is high.
- All outputs are registered, or decoded combinationally from registers only.
- Trigger sampled at edge k: volume = init_vol after edge k, and env_active = 1 after edge k if the next state is RUN.
- First step lands at edge k+period. Subsequent steps follow every period edges.
- dac_en follows the write: it changes after the edge that samples wr_en.
- Trigger while in RUN: restarts the envelope (vol, cnt, dir, period reloaded) at that edge. No step is applied at that edge.
- DAC-off write and trigger on the same channel in the same cycle: the channel ends IDLE with vol 0.
- Reset asserted mid-envelope: the channel returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then write ch0 = {13, dec, 4}, then trigger ch0 at edge 0. Required: vol0 = 13 after edge 0, 12 after edge 4, 11 after edge 8. env_active[0] = 1 throughout.
- Write ch1 = {13, inc, 1}, then trigger. Required: vol1 = 13, 14, 15 on successive edges. After the edge reaching 15, env_active[1] = 0 and vol1 stays at 15 for 10 more edges.
- Write ch2 = {7, dec, 0}, then trigger. Required: vol2 = 7 and held for 20 edges; env_active[2] = 0 (HOLD). Then write ch2 = 0. Required: dac_en[2] = 0 and vol2 = 0 on the next edge; a later trigger leaves vol2 at 0.
- Ch0 running {10, dec, 2}: write ch0 = {3, inc, 1} mid-envelope. Required: the envelope continues decrementing by 1 every 2 edges. Then trigger ch0 together with a write of {5, inc, 1}. Required: vol0 = 5, then 6 one edge later.
- Trigger all 4 channels in the same cycle with distinct configs. Required: each channel follows its own config independently. Assert reset mid-run. Required: all volumes = 0 and dac_en = 0 before the next edge.
- Write with wr_ch ≥ NUM_CH (for example NUM_CH = 3, wr_ch = 3). Required: no channel's cfg or dac_en changes.
